bcd_stopwatch_ctrl: RTL

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

---
 rtl/bcd_stopwatch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_ctrl
// Description : Stopwatch controller with a cascaded BCD counter, IDLE/RUN/
//               PAUSE/LAP state machine, lap-freeze display register,
//               wrap-carry pulse and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  clear_i,
    input  logic                  lap_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic [4*DIGITS-1:0]   disp_o,
    output logic [1:0]            state_o,
    output logic                  carry_o,
    output logic                  ovf_o
);

    localparam int c_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t             r_state;
    logic [c_W-1:0]     r_cnt;
    logic [c_W-1:0]     r_lap;
    logic               r_carry;
    logic               r_ovf;

    state_t             w_next_state;
    logic               w_count_en;
    logic               w_lap_cap;

    // w_low9[k]  : digits 0..k-1 of the live count are all 9
    // w_step9[k] : digits 0..k-1 of the post-tick count are all 9
    logic [DIGITS:0]    w_low9;
    logic [DIGITS:0]    w_step9;
    logic [c_W-1:0]     w_inc;
    logic [c_W-1:0]     w_step;
    logic               w_all9;
    logic               w_step_all9;

    assign w_low9[0]  = 1'b1;
    assign w_step9[0] = 1'b1;

    // Per-digit ripple: a digit advances only when every lower digit is 9
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_d;
        assign w_d                 = r_cnt[4*gi +: 4];
        assign w_inc[4*gi +: 4]    = !w_low9[gi]   ? w_d  :
                                     (w_d == 4'd9) ? 4'd0 : (w_d + 4'd1);
        assign w_low9[gi+1]        = w_low9[gi] & (w_d == 4'd9);
        assign w_step9[gi+1]       = w_step9[gi] & (w_step[4*gi +: 4] == 4'd9);
    end

    assign w_all9      = w_low9[DIGITS];
    // Saturating variant pins the count at all-nines instead of rolling over
    assign w_step      = ((SATURATE != 0) && w_all9) ? r_cnt : w_inc;
    assign w_step_all9 = w_step9[DIGITS];

    // Command decode: stop beats start beats lap; clear is handled at the register
    always_comb begin
        w_next_state = r_state;
        if (stop_i) begin
            if (r_state == ST_RUN || r_state == ST_LAP) begin
                w_next_state = ST_PAUSE;
            end
        end else if (start_i) begin
            if (r_state == ST_IDLE || r_state == ST_PAUSE) begin
                w_next_state = ST_RUN;
            end
        end else if (lap_i) begin
            if (r_state == ST_RUN) begin
                w_next_state = ST_LAP;
            end else if (r_state == ST_LAP) begin
                w_next_state = ST_RUN;
            end
        end
        // A stop in RUN/LAP always pauses, so it also freezes that cycle's tick
        w_count_en = (r_state == ST_RUN || r_state == ST_LAP) && tick_i && !stop_i && !clear_i;
        w_lap_cap  = (r_state == ST_RUN) && lap_i && !stop_i && !start_i && !clear_i;
    end

    // State, counter, lap register and flags; reset and clear zero everything
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lap   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_carry <= 1'b0;
            // Lap snapshot takes the pre-increment count
            if (w_lap_cap) begin
                r_lap <= r_cnt;
            end
            if (w_count_en) begin
                r_cnt <= w_step;
                if ((SATURATE == 0) && w_all9) begin
                    r_carry <= 1'b1;
                    r_ovf   <= 1'b1;
                end
                if ((SATURATE != 0) && w_step_all9) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign cnt_o   = r_cnt;
    assign disp_o  = (r_state == ST_LAP) ? r_lap : r_cnt;
    assign state_o = r_state;
    assign carry_o = r_carry;
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire
